// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the execute stage and the iterative
// multiply/divide unit.
//   master (EX side)  : drives start, op, a, b, cancel; observes busy, done, hi, lo, dbz
//   slave  (MDU side) : the reverse
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dbz;

  modport master (output start, op, a, b, cancel,
                  input  busy, done, hi, lo, dbz);
  modport slave  (input  start, op, a, b, cancel,
                  output busy, done, hi, lo, dbz);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU engine, one result bit per clock.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mdu_if slave port
//     start/op/a/b : request, sampled only while not busy
//                    (op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//     cancel       : flush, aborts any in-flight operation
//     busy         : high while iterating or fixing up signs
//     done         : one-cycle pulse, hi/lo/dbz valid with it
//     hi/lo        : product halves, or remainder/quotient
//     dbz          : last completed op was a divide by zero (held)
// Signed operands are reduced to magnitudes at acceptance; the unsigned core
// runs WIDTH iterations, then a single FIX cycle applies the sign correction.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      counter_reg;
  logic [WIDTH:0]     opa_reg;      // multiplicand magnitude
  logic [WIDTH:0]     opb_reg;      // divisor magnitude
  logic [2*WIDTH-1:0] pair_reg;     // {acc, multiplier} or {-, quotient}
  logic [WIDTH-1:0]   rem_reg;      // partial remainder (always < divisor)
  logic               is_div_reg;
  logic               res_neg_reg;  // operand signs differ
  logic               rem_neg_reg;  // dividend was negative
  logic               bzero_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               dbz_reg;

  logic accept, calc_step, fix_load;

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    calc_step  = 1'b0;
    fix_load   = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CALC: begin
        calc_step = 1'b1;
        if (counter_reg == CW'(WIDTH - 1)) state_next = S_FIX;
      end
      S_FIX: begin
        fix_load   = 1'b1;
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
    // Flush wins over everything, including a start in the same cycle.
    if (bus.cancel) begin
      state_next = S_IDLE;
      accept     = 1'b0;
      calc_step  = 1'b0;
      fix_load   = 1'b0;
    end
  end

  assign bus.busy = (state_reg == S_CALC) || (state_reg == S_FIX);
  assign bus.done = (state_reg == S_DONE);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
  assign bus.dbz  = dbz_reg;

  // ---------------- operand conditioning ----------------
  logic           a_neg, b_neg;
  logic [WIDTH:0] a_mag, b_mag;

  // op[0]=0 selects the signed forms. Negation in WIDTH+1 bits keeps the
  // magnitude of the most-negative value (2^(WIDTH-1)) exact.
  assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? ({1'b0, ~bus.a} + (WIDTH+1)'(1)) : {1'b0, bus.a};
  assign b_mag = b_neg ? ({1'b0, ~bus.b} + (WIDTH+1)'(1)) : {1'b0, bus.b};

  // ---------------- iteration datapath ----------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_pair_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_diff;

  // Shift-add: the carry out of the add becomes the new top bit after the
  // right shift, so nothing is lost.
  assign mul_sum       = {1'b0, pair_reg[2*WIDTH-1:WIDTH]} + (pair_reg[0] ? opa_reg : '0);
  assign mul_pair_next = {mul_sum, pair_reg[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder.
  assign div_shift = {rem_reg, pair_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= opb_reg);
  assign div_diff  = div_shift - opb_reg;

  // ---------------- sign fixup ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = res_neg_reg ? (~pair_reg + (2*WIDTH)'(1)) : pair_reg;
  assign quo_fix  = res_neg_reg ? (~pair_reg[WIDTH-1:0] + WIDTH'(1)) : pair_reg[WIDTH-1:0];
  assign rem_fix  = rem_neg_reg ? (~rem_reg + WIDTH'(1)) : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_reg <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      pair_reg    <= '0;
      rem_reg     <= '0;
      is_div_reg  <= 1'b0;
      res_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
      bzero_reg   <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      dbz_reg     <= 1'b0;
    end else begin
      if (accept) begin
        counter_reg <= '0;
        opa_reg     <= a_mag;
        opb_reg     <= b_mag;
        rem_reg     <= '0;
        is_div_reg  <= bus.op[1];
        res_neg_reg <= a_neg ^ b_neg;
        rem_neg_reg <= a_neg;
        bzero_reg   <= (bus.b == '0);
        // Multiply iterates over the multiplier; divide shifts out the dividend.
        pair_reg    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0])};
      end else if (calc_step) begin
        counter_reg <= counter_reg + CW'(1);
        if (is_div_reg) begin
          rem_reg              <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          pair_reg[WIDTH-1:0]  <= {pair_reg[WIDTH-2:0], div_ge};
        end else begin
          pair_reg <= mul_pair_next;
        end
      end
      if (fix_load) begin
        if (is_div_reg) begin
          hi_reg  <= rem_fix;
          lo_reg  <= quo_fix;
          dbz_reg <= bzero_reg;
        end else begin
          hi_reg  <= prod_fix[2*WIDTH-1:WIDTH];
          lo_reg  <= prod_fix[WIDTH-1:0];
          dbz_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mdu_if #(.WIDTH(WIDTH)) bus();

  mdu_iter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one edge (E0); returns #1 after E0 with start low.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Edges already consumed since and including E0 are passed in; returns
  // the edge count at which done was first seen (bounded).
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!bus.done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int cyc;
    start_op(op, a, b);
    wait_done(1, cyc);
    check({tag, " latency"}, 64'(cyc), 64'(LAT));
    check({tag, " hi"},  64'(bus.hi),  64'(ehi));
    check({tag, " lo"},  64'(bus.lo),  64'(elo));
    check({tag, " dbz"}, 64'(bus.dbz), 64'(edbz));
    $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0d cycles=%0d",
             op, a, b, bus.hi, bus.lo, bus.dbz, cyc);
  endtask

  initial begin
    int cyc;
    int done_seen;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    tick();
    tick();
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset hi",   64'(bus.hi),   64'(0));
    check("reset lo",   64'(bus.lo),   64'(0));
    check("reset dbz",  64'(bus.dbz),  64'(0));
    rst = 1'b0;
    tick();

    // MULTU max*max, with a busy check right after acceptance.
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu busy after E0", 64'(bus.busy), 64'(1));
    wait_done(1, cyc);
    check("multu latency", 64'(cyc), 64'(LAT));
    check("multu busy at done", 64'(bus.busy), 64'(0));
    check("multu hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
    $display("MULTU max*max -> hi=0x%08h lo=0x%08h cycles=%0d", bus.hi, bus.lo, cyc);
    tick();
    check("done single pulse", 64'(bus.done), 64'(0));
    check("hi held after done", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);

    run_op("mult -3*5",     2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div -7/2",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu 7/0",      2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    // Signed divide by zero: all-ones quotient negated (signs differ) -> 1, remainder = a.
    run_op("div -8/0",      2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'h0000_0001, 1'b1);
    run_op("mult -6*-7",    2'b00, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'h0000_0000, 32'd42,        1'b0);
    run_op("divu 100/7",    2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op("div 7/-2",      2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    tick();

    // Cancel mid-operation: previous result (7/-2) must survive.
    start_op(2'b11, 32'd100, 32'd7);
    repeat (9) tick();
    bus.cancel = 1'b1;
    bus.start  = 1'b1;   // simultaneous start must be dropped
    tick();
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'(0));
    done_seen = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("cancel no done", 64'(done_seen), 64'(0));
    check("cancel hi kept", 64'(bus.hi),  64'(32'd1));
    check("cancel lo kept", 64'(bus.lo),  64'(32'hFFFF_FFFD));
    check("cancel dbz kept", 64'(bus.dbz), 64'(0));
    $display("cancel: done pulses=%0d hi=0x%08h lo=0x%08h", done_seen, bus.hi, bus.lo);

    // Starts and operand changes while busy are ignored.
    start_op(2'b11, 32'd100, 32'd7);
    bus.op = 2'b01;
    bus.a  = 32'd9;
    bus.b  = 32'd3;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    check("busy after ignored starts", 64'(bus.busy), 64'(1));
    check("hi stable while busy", 64'(bus.hi), 64'(32'd1));
    wait_done(6, cyc);
    check("latched latency", 64'(cyc), 64'(LAT));
    check("latched lo", 64'(bus.lo), 64'(32'd14));
    check("latched hi", 64'(bus.hi), 64'(32'd2));
    $display("DIVU 100/7 with busy starts -> hi=%0d lo=%0d cycles=%0d", bus.hi, bus.lo, cyc);

    // Back-to-back: start in the DONE cycle.
    run_op("b2b multu 6*7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // Reset mid-operation aborts with no done and clears results.
    tick();
    start_op(2'b00, 32'd3, 32'd3);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midop reset busy", 64'(bus.busy), 64'(0));
    check("midop reset lo",   64'(bus.lo),   64'(0));
    done_seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("midop reset no done", 64'(done_seen), 64'(0));
    $display("mid-op reset: busy=%0d lo=0x%08h done pulses=%0d", bus.busy, bus.lo, done_seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
